dm_port_arbiter: RTL and testbench

//   Shares the single data-memory port (word-addressed RAM, combinational read, write at

---
 rtl/dm_port_arbiter.sv | 82 ++++++++
 tb/tb_dm_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the data-memory port between the CPU M-stage (priority) and a burst DMA.
// DMA bursts are capped at MAX_BURST beats; STARVE_LIMIT denied cycles force a DMA grant.
module dm_port_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        burst_active,
    output logic        mem_we,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic {IDLE, DMA_BURST} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [7:0] LIMIT     = 8'(STARVE_LIMIT);

    state_t     state, state_n;
    logic [7:0] beat_cnt, beat_n, starve_cnt, starve_n;
    logic       force_dma, own_cpu, own_dma;

    assign force_dma = state == IDLE && starve_cnt == LIMIT && dma_req;
    assign own_cpu   = state == IDLE && cpu_req && !force_dma;
    assign own_dma   = dma_req && !own_cpu;

    // Writes are suppressed while reset is held so a half-finished beat never commits.
    assign mem_we       = !reset && (own_cpu ? cpu_we : own_dma && dma_we);
    assign mem_op       = own_cpu ? cpu_op : 2'b00;
    assign mem_addr     = own_cpu ? cpu_addr : own_dma ? dma_addr & ~32'h3 : 32'h0;
    assign mem_wdata    = own_cpu ? cpu_wdata : own_dma ? dma_wdata : 32'h0;
    assign cpu_stall    = cpu_req && !own_cpu;
    assign dma_gnt      = own_dma;
    assign cpu_rdata    = mem_rdata;
    assign dma_rdata    = mem_rdata;
    assign burst_active = state == DMA_BURST;

    always_comb begin
        state_n  = state;
        beat_n   = beat_cnt;
        starve_n = own_dma ? 8'd0 : !dma_req ? 8'd0 : starve_cnt == LIMIT ? LIMIT : starve_cnt + 8'd1;
        if (state == IDLE) begin
            if (own_dma && !dma_last && MAX_BURST > 1) begin
                state_n = DMA_BURST;
                beat_n  = 8'd1;
            end
        end else if (dma_req && !dma_last && beat_cnt != LAST_BEAT) begin
            beat_n = beat_cnt + 8'd1;
        end else begin
            state_n = IDLE;
            beat_n  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= 8'd0;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_n;
            beat_cnt   <= beat_n;
            starve_cnt <= starve_n;
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed vector table, reset-mid-burst sequence and random stimulus
// checked against a behavioural model of the arbitration rules.
module tb_dm_port_arbiter;
    localparam int MAXB = 8;
    localparam int LIM  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_stall, dma_req, dma_we, dma_last, dma_gnt, burst_active, mem_we;
    logic [1:0]  cpu_op, mem_op;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram [256] = '{default: 32'h0};

    always #5 clk = ~clk;
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;

    dm_port_arbiter #(.MAX_BURST(MAXB), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .burst_active(burst_active), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        cr, cw, dr, dw, dl;
        logic [1:0]  op;
        logic [31:0] ca, cd, da, dd;
        logic        e_stall, e_gnt, e_we, e_burst, chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    int   compared = 0;
    int   mismatched = 0;
    vec_t tbl[$];

    // Model: whether DMA currently owns the port, beats used in this ownership, denied streak.
    bit m_owns;
    int m_beats, m_denied;

    function automatic vec_t mk(bit cr, bit cw, logic [31:0] ca, logic [31:0] cd, bit dr, bit dw,
                                bit dl, logic [31:0] da, logic [31:0] dd, bit es, bit eg, bit ew,
                                bit eb, bit crd, logic [31:0] erd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.op = 2'b00; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
        v.e_stall = es; v.e_gnt = eg; v.e_we = ew; v.e_burst = eb; v.chk_rd = crd; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        cpu_req = v.cr; cpu_we = v.cw; cpu_op = v.op; cpu_addr = v.ca; cpu_wdata = v.cd;
        dma_req = v.dr; dma_we = v.dw; dma_last = v.dl; dma_addr = v.da; dma_wdata = v.dd;
    endtask

    task automatic cycle(input vec_t v, input bit tbl_chk, input string tag);
        bit          cpu_first, dma_served;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [1:0]  e_op;
        bit          e_we;
        @(negedge clk);
        apply(v);
        #2;
        cpu_first  = !m_owns && v.cr && !(m_denied >= LIM && v.dr);
        dma_served = v.dr && !cpu_first;
        e_addr = cpu_first ? v.ca : dma_served ? {v.da[31:2], 2'b00} : 32'h0;
        e_wd   = cpu_first ? v.cd : dma_served ? v.dd : 32'h0;
        e_op   = cpu_first ? v.op : 2'b00;
        e_we   = cpu_first ? v.cw : dma_served && v.dw;
        e_rd   = ram[e_addr[9:2]];
        chk({tag, ".stall"}, 32'(cpu_stall), 32'(v.cr && !cpu_first));
        chk({tag, ".gnt"}, 32'(dma_gnt), 32'(dma_served));
        chk({tag, ".burst"}, 32'(burst_active), 32'(m_owns));
        chk({tag, ".we"}, 32'(mem_we), 32'(e_we));
        chk({tag, ".op"}, 32'(mem_op), 32'(e_op));
        chk({tag, ".addr"}, mem_addr, e_addr);
        chk({tag, ".wdata"}, mem_wdata, e_wd);
        chk({tag, ".cpu_rdata"}, cpu_rdata, e_rd);
        chk({tag, ".dma_rdata"}, dma_rdata, e_rd);
        if (tbl_chk) begin
            chk({tag, ".tbl_stall"}, 32'(cpu_stall), 32'(v.e_stall));
            chk({tag, ".tbl_gnt"}, 32'(dma_gnt), 32'(v.e_gnt));
            chk({tag, ".tbl_we"}, 32'(mem_we), 32'(v.e_we));
            chk({tag, ".tbl_burst"}, 32'(burst_active), 32'(v.e_burst));
            if (v.chk_rd) begin
                chk({tag, ".tbl_cpu_rd"}, cpu_rdata, v.e_rd);
                chk({tag, ".tbl_dma_rd"}, dma_rdata, v.e_rd);
            end
        end
        if (dma_served) begin
            m_beats++;
            if (v.dl || m_beats == MAXB) begin
                m_owns = 0;
                m_beats = 0;
            end else m_owns = 1;
        end else if (m_owns) begin
            m_owns = 0;
            m_beats = 0;
        end
        m_denied = dma_served ? 0 : !v.dr ? 0 : (m_denied + 1 > LIM ? LIM : m_denied + 1);
    endtask

    initial begin
        vec_t z, r;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(z);
        reset = 1'b1;
        m_owns = 0; m_beats = 0; m_denied = 0;
        #1;
        chk("rst.burst", 32'(burst_active), 32'h0);
        chk("rst.gnt", 32'(dma_gnt), 32'h0);
        chk("rst.stall", 32'(cpu_stall), 32'h0);
        chk("rst.we", 32'(mem_we), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back(mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h100, 32'hA1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 32'h104, 32'hA2, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 32'h108, 32'hA3, 0, 1, 1, 1, 0, 0));
        tbl.push_back(z);
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 32'h105, 0, 0, 1, 0, 0, 1, 32'hA2));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 1, 32'h100, 0, 1, 1, 0, 0, 1, 32'hA1));
        tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(k > 0, 0, 32'h10, 0, 1, 1, 0, 32'h200 + 32'(4 * k), 32'hB0 + 32'(k),
                             k > 0, 1, 1, k > 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 0, 32'h300, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        tbl.push_back(z);
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h200, 0, 0, 1, 0, 0, 1, 32'hB0));
        tbl.push_back(mk(1, 0, 32'h10, 0, 1, 0, 0, 32'h204, 0, 1, 1, 0, 1, 1, 32'hB1));
        tbl.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], 1, $sformatf("vec%0d", i));

        // Reset during beat 4 of a write burst.
        cycle(z, 0, "pre");
        for (int k = 0; k < 3; k++)
            cycle(mk(0, 0, 0, 0, 1, 1, 0, 32'h300 + 32'(4 * k), 32'hC0 + 32'(k), 0, 1, 1, k > 0, 0, 0),
                  1, $sformatf("rb%0d", k));
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 1, 1, 0, 32'h30C, 32'hDEAD0004, 0, 0, 0, 0, 0, 0));
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.burst", 32'(burst_active), 32'h0);
        chk("rst_mid.we", 32'(mem_we), 32'h0);
        @(negedge clk);
        chk("rst_mid.no_write", ram[8'hC3], 32'h0);
        apply(z);
        reset = 1'b0;
        m_owns = 0; m_beats = 0; m_denied = 0;
        for (int k = 0; k < 8; k++)
            cycle(mk(k > 0, 0, 32'h10, 0, 1, 1, 0, 32'h340 + 32'(4 * k), 32'hD0 + 32'(k),
                     k > 0, 1, 1, k > 0, 0, 0), 1, $sformatf("nb%0d", k));
        cycle(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF), 1, "nb_end");

        for (int i = 0; i < 3000; i++) begin
            r = z;
            r.cr = ($urandom_range(0, 1) == 1);
            r.cw = ($urandom_range(0, 1) == 1);
            r.op = 2'($urandom_range(0, 2));
            r.ca = $urandom;
            r.cd = $urandom;
            r.dr = ($urandom_range(0, 9) < 7);
            r.dw = ($urandom_range(0, 1) == 1);
            r.dl = ($urandom_range(0, 9) < 2);
            r.da = $urandom;
            r.dd = $urandom;
            cycle(r, 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
